// File: rtl/hack_pkg.sv
// Shared definitions for the Hack CPU sequencer: state encoding, instruction bit positions, reset vector.
package hack_pkg;

    localparam int unsigned XLEN = 16;

    // Bit positions inside a Hack C-instruction
    localparam int unsigned C_BIT = 15;
    localparam int unsigned J1    = 2;
    localparam int unsigned J2    = 1;
    localparam int unsigned J3    = 0;

    localparam logic [XLEN-1:0] RESET_VECTOR_DEF = 16'h0000;

    typedef enum logic [2:0] {
        BOOT,
        FETCH,
        EXEC,
        HALT,
        ERROR
    } seq_state_e;

endpackage

// File: rtl/hack_jump_unit.sv
// Hack jump resolution: decides whether a C-instruction jumps and produces the following pc.
module hack_jump_unit
    import hack_pkg::*;
(
    input  logic [XLEN-1:0] instr,
    input  logic            alu_zr,
    input  logic            alu_ng,
    input  logic [XLEN-1:0] a_reg,
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] next_pc,
    output logic            taken
);

    // comp/dest fields are decoded by the datapath, not here
    logic unused_instr_bits;
    assign unused_instr_bits = ^instr[C_BIT-1:J1+1];

    always_comb begin
        taken   = instr[C_BIT] & ((instr[J1] & alu_ng) |
                                  (instr[J2] & alu_zr) |
                                  (instr[J3] & ~alu_ng & ~alu_zr));
        next_pc = taken ? a_reg : pc + XLEN'(1);
    end

endmodule

// File: rtl/hack_seq_ctrl.sv
// Fetch/execute sequencer for the Hack CPU: owns pc, fetches over req/ack, one-cycle execute strobe.
// Optional breakpoint compare is enabled by defining HACK_SEQ_BREAKPOINT_EN.
module hack_seq_ctrl
    import hack_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR  = RESET_VECTOR_DEF,
    parameter int unsigned     FETCH_TIMEOUT = 255,
    parameter int unsigned     TO_W          = 8
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] instr,
    output logic            instr_valid,
    input  logic            alu_zr,
    input  logic            alu_ng,
    input  logic [XLEN-1:0] a_reg,
    output logic [XLEN-1:0] pc,
    input  logic            halt_req,
    input  logic            step_req,
    output logic            halted,
`ifdef HACK_SEQ_BREAKPOINT_EN
    input  logic            bp_en,
    input  logic [XLEN-1:0] bp_addr,
    output logic            bp_hit,
`endif
    output logic            fetch_err
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(FETCH_TIMEOUT - 1);

    seq_state_e      state;
    logic [TO_W-1:0] to_cnt;
    logic            step_flag;
    logic [XLEN-1:0] jump_pc_c;
    logic            jump_taken_unused;
    logic            bp_trip_c;

    hack_jump_unit u_jump (
        .instr   (instr),
        .alu_zr  (alu_zr),
        .alu_ng  (alu_ng),
        .a_reg   (a_reg),
        .pc      (pc),
        .next_pc (jump_pc_c),
        .taken   (jump_taken_unused)
    );

    assign imem_addr = pc;

`ifdef HACK_SEQ_BREAKPOINT_EN
    // Compare the pc about to be fetched; the HALT->FETCH resume path never consults this.
    always_comb begin
        bp_trip_c = 1'b0;
        if (bp_en) begin
            if (state == BOOT) begin
                bp_trip_c = (pc == bp_addr);
            end else if (state == EXEC && !halt_req && !step_flag) begin
                bp_trip_c = (jump_pc_c == bp_addr);
            end
        end
    end
`else
    assign bp_trip_c = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= BOOT;
            pc          <= RESET_VECTOR;
            instr       <= '0;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
            fetch_err   <= 1'b0;
            to_cnt      <= '0;
            step_flag   <= 1'b0;
`ifdef HACK_SEQ_BREAKPOINT_EN
            bp_hit      <= 1'b0;
`endif
        end else begin
            instr_valid <= 1'b0;
`ifdef HACK_SEQ_BREAKPOINT_EN
            bp_hit      <= bp_trip_c;
`endif
            unique case (state)
                BOOT: begin
                    if (bp_trip_c) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end else begin
                        state    <= FETCH;
                        imem_req <= 1'b1;
                    end
                end
                FETCH: begin
                    // An ack arriving on the final allowed cycle still completes the fetch
                    if (imem_ack) begin
                        instr       <= imem_rdata;
                        to_cnt      <= '0;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                        state       <= EXEC;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                        if (to_cnt == TO_LAST) begin
                            state     <= ERROR;
                            imem_req  <= 1'b0;
                            fetch_err <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    pc <= jump_pc_c;
                    if (halt_req || step_flag) begin
                        state     <= HALT;
                        halted    <= 1'b1;
                        step_flag <= 1'b0;
                    end else if (bp_trip_c) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end else begin
                        state    <= FETCH;
                        imem_req <= 1'b1;
                    end
                end
                HALT: begin
                    if (step_req || !halt_req) begin
                        step_flag <= step_req;
                        state     <= FETCH;
                        halted    <= 1'b0;
                        imem_req  <= 1'b1;
                    end
                end
                ERROR: begin
                    state <= ERROR;
                end
                default: begin
                    state     <= ERROR;
                    imem_req  <= 1'b0;
                    fetch_err <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hack_seq_ctrl.sv
// Self-checking bench for hack_seq_ctrl: directed timing checks plus randomized run against a pc model.
module tb_hack_seq_ctrl;

    localparam int unsigned TO = 4;

    logic        clk        = 1'b0;
    logic        reset      = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack   = 1'b0;
    logic [15:0] imem_rdata = 16'h0000;
    logic [15:0] instr;
    logic        instr_valid;
    logic        alu_zr     = 1'b0;
    logic        alu_ng     = 1'b0;
    logic [15:0] a_reg      = 16'h0000;
    logic [15:0] pc;
    logic        halt_req   = 1'b0;
    logic        step_req   = 1'b0;
    logic        halted;
    logic        fetch_err;

    hack_seq_ctrl #(
        .RESET_VECTOR  (16'h0000),
        .FETCH_TIMEOUT (TO),
        .TO_W          (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .alu_zr      (alu_zr),
        .alu_ng      (alu_ng),
        .a_reg       (a_reg),
        .pc          (pc),
        .halt_req    (halt_req),
        .step_req    (step_req),
        .halted      (halted),
        .fetch_err   (fetch_err)
    );

    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad   = 0;

    // Memory / flag environment controls
    bit          ack_en     = 1'b1;
    bit          rand_prog  = 1'b0;
    bit          rand_flags = 1'b0;
    bit          sb_en      = 1'b0;
    int unsigned lat_min    = 0;
    int unsigned lat_max    = 0;
    int unsigned wait_left  = 0;
    logic [15:0] fixed_word = 16'h0123;
    logic        dir_zr     = 1'b0;
    logic        dir_ng     = 1'b0;
    logic [15:0] dir_a      = 16'h0000;
    logic [15:0] model_pc   = 16'h0000;
    logic [15:0] last_word  = 16'h0000;
    int unsigned exec_seen  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Hack jump semantics: the ALU result is lt/eq/gt zero, j1 j2 j3 select which of those jump
    function automatic logic [15:0] ref_next(input logic [15:0] w, input logic zr, input logic ng,
                                             input logic [15:0] tgt, input logic [15:0] cur);
        logic [2:0] cond;
        cond = {ng, zr, ~(ng | zr)};
        if (w[15] && ((w[2:0] & cond) != 3'b000)) return tgt;
        return cur + 16'd1;
    endfunction

    function automatic logic [15:0] rand_word();
        logic [15:0] w;
        w = 16'($urandom);
        if (w[15]) w[14:13] = 2'b11;
        return w;
    endfunction

    // Memory responder, flag driver and pc scoreboard, all away from the active edge
    always @(negedge clk) begin
        alu_zr = rand_flags ? 1'($urandom_range(1, 0)) : dir_zr;
        alu_ng = rand_flags ? 1'($urandom_range(1, 0)) : dir_ng;
        a_reg  = rand_flags ? 16'($urandom) : dir_a;
        imem_ack = 1'b0;
        if (imem_req && ack_en) begin
            if (wait_left == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = rand_prog ? rand_word() : fixed_word;
                last_word  = imem_rdata;
                if (sb_en) check("fetch_addr", 32'(imem_addr), 32'(model_pc));
                wait_left = $urandom_range(lat_max, lat_min);
            end else begin
                wait_left--;
            end
        end
        if (instr_valid) begin
            exec_seen++;
            if (sb_en) begin
                check("exec_pc", 32'(pc), 32'(model_pc));
                check("exec_instr", 32'(instr), 32'(last_word));
                model_pc = ref_next(last_word, alu_zr, alu_ng, a_reg, model_pc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_exec(input int unsigned budget, input string tag);
        int unsigned n = 0;
        do begin
            tick();
            n++;
        end while (!instr_valid && n < budget);
        check(tag, 32'(instr_valid), 32'd1);
    endtask

    task automatic enter_reset(input int unsigned first_wait);
        reset     = 1'b0;
        model_pc  = 16'h0000;
        wait_left = first_wait;
        repeat (2) tick();
    endtask

    initial begin
        int unsigned v0;
        int unsigned k_hit;
        int unsigned req_cycles;
        bit          seen;

        // Reset values
        repeat (3) tick();
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_pc", 32'(pc), 32'h0000);
        check("rst_instr", 32'(instr), 32'h0000);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_err", 32'(fetch_err), 32'd0);

        // Zero-wait memory, A-instructions: BOOT cycle, then one instruction per two cycles
        fixed_word = 16'h0123;
        sb_en      = 1'b1;
        reset      = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check("boot_req", 32'(imem_req), 32'((k % 2) == 1));
            check("boot_valid", 32'(instr_valid), 32'((k % 2) == 0));
            check("boot_pc", 32'(pc), 32'((k - 1) / 2));
        end

        // Unconditional jump, then a JEQ that must fall through
        fixed_word = 16'hE307;
        dir_a      = 16'h0040;
        wait_exec(10, "jmp_exec");
        check("jmp_instr", 32'(instr), 32'hE307);
        fixed_word = 16'hE302;
        dir_zr     = 1'b0;
        dir_ng     = 1'b0;
        tick();
        check("jmp_taken", 32'(pc), 32'h0040);
        wait_exec(10, "jeq_exec");
        tick();
        check("jeq_not_taken", 32'(pc), 32'h0041);

        // Wrap from 0xFFFF
        fixed_word = 16'hE307;
        dir_a      = 16'hFFFF;
        wait_exec(10, "wrap_jmp_exec");
        fixed_word = 16'h0005;
        tick();
        check("wrap_at_ffff", 32'(pc), 32'hFFFF);
        wait_exec(10, "wrap_exec");
        tick();
        check("wrap_pc", 32'(pc), 32'h0000);

        // Randomized run with variable memory latency
        rand_prog  = 1'b1;
        rand_flags = 1'b1;
        lat_min    = 0;
        lat_max    = 2;
        repeat (400) tick();

        // Halt: the in-flight instruction completes, then pc freezes
        v0       = exec_seen;
        halt_req = 1'b1;
        for (int n = 0; n < 20 && !halted; n++) tick();
        check("halt_reached", 32'(halted), 32'd1);
        check("halt_drain", exec_seen - v0, 32'd1);
        repeat (6) tick();
        check("halt_pc_frozen", 32'(pc), 32'(model_pc));
        check("halt_no_req", 32'(imem_req), 32'd0);
        check("halt_held", 32'(halted), 32'd1);

        // Single steps while halt_req stays high
        for (int s = 0; s < 3; s++) begin
            v0       = exec_seen;
            step_req = 1'b1;
            tick();
            step_req = 1'b0;
            repeat (12) tick();
            check("step_one_instr", exec_seen - v0, 32'd1);
            check("step_rehalted", 32'(halted), 32'd1);
            check("step_pc", 32'(pc), 32'(model_pc));
        end

        // Step together with halt release: step wins, so one more HALT visit before running
        step_req = 1'b1;
        halt_req = 1'b0;
        tick();
        step_req = 1'b0;
        seen     = 1'b0;
        for (int n = 0; n < 12; n++) begin
            tick();
            if (halted) seen = 1'b1;
        end
        check("step_priority", 32'(seen), 32'd1);
        v0 = exec_seen;
        repeat (30) tick();
        check("resume_running", 32'((exec_seen - v0) >= 6), 32'd1);

        // step_req outside HALT is ignored
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        seen     = 1'b0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (halted) seen = 1'b1;
        end
        check("step_ignored", 32'(seen), 32'd0);

        // Ack on the last allowed FETCH cycle wins over the timeout
        enter_reset(TO - 1);
        lat_min = TO - 1;
        lat_max = TO - 1;
        reset   = 1'b1;
        k_hit   = 0;
        for (int k = 1; k <= 12 && k_hit == 0; k++) begin
            tick();
            if (instr_valid) k_hit = k;
        end
        check("ack_wins_cycle", k_hit, TO + 1);
        check("ack_wins_err", 32'(fetch_err), 32'd0);

        // Memory never acks: ERROR after TO FETCH cycles
        enter_reset(0);
        ack_en     = 1'b0;
        reset      = 1'b1;
        req_cycles = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (imem_req) req_cycles++;
            if (k == TO) check("to_err_early", 32'(fetch_err), 32'd0);
            if (k == TO + 1) check("to_err_set", 32'(fetch_err), 32'd1);
        end
        check("to_req_cycles", req_cycles, TO);
        ack_en = 1'b1;
        repeat (20) tick();
        check("err_sticky", 32'(fetch_err), 32'd1);
        check("err_no_req", 32'(imem_req), 32'd0);
        check("err_pc", 32'(pc), 32'h0000);

        // Asynchronous reset clears ERROR and drops a pending request
        reset = 1'b0;
        #1;
        check("rst_clears_err", 32'(fetch_err), 32'd0);
        tick();
        model_pc  = 16'h0000;
        wait_left = 3;
        reset     = 1'b1;
        tick();
        check("refetch_req", 32'(imem_req), 32'd1);
        reset = 1'b0;
        #1;
        check("rst_drops_req", 32'(imem_req), 32'd0);
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute guard against a stuck run
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
